// File: rtl/pass_sched_pkg.sv
// Shared definitions for the layer-level pass scheduler.
//   pass_state_t : sequencer state encoding
//   OP_START_BIT : bit of op_config that launches the pass controller
//   ADDR_W       : byte-address width of the GLB regions
package pass_sched_pkg;

  localparam int unsigned OP_START_BIT = 0;
  localparam int unsigned ADDR_W       = 32;

  typedef enum logic [2:0] {
    StIdle,
    StLaunch,
    StWait,
    StNext,
    StDone
  } pass_state_t;

endpackage

// File: rtl/pass_addr_gen.sv
// Base-address pointer unit for the pass scheduler.
// Holds the filter/ifmap/bias/opsum pointers and their strides, advancing them by addition only.
//   load_i   : pointers <- bases, strides and ifmap base captured
//   step_c_i : next input-channel tile (filter += fs, ifmap += is)
//   step_m_i : next output-channel tile (filter += fs, ifmap <- base, bias += bs, opsum += os)
//   *_addr_o : current pointers, driven straight from registers
module pass_addr_gen
  import pass_sched_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic              step_c_i,
  input  logic              step_m_i,
  input  logic [ADDR_W-1:0] filter_base_i,
  input  logic [ADDR_W-1:0] ifmap_base_i,
  input  logic [ADDR_W-1:0] bias_base_i,
  input  logic [ADDR_W-1:0] opsum_base_i,
  input  logic [ADDR_W-1:0] filter_stride_i,
  input  logic [ADDR_W-1:0] ifmap_stride_i,
  input  logic [ADDR_W-1:0] bias_stride_i,
  input  logic [ADDR_W-1:0] opsum_stride_i,
  output logic [ADDR_W-1:0] filter_addr_o,
  output logic [ADDR_W-1:0] ifmap_addr_o,
  output logic [ADDR_W-1:0] bias_addr_o,
  output logic [ADDR_W-1:0] opsum_addr_o
);

  logic [ADDR_W-1:0] filter_q, filter_d;
  logic [ADDR_W-1:0] ifmap_q, ifmap_d;
  logic [ADDR_W-1:0] bias_q, bias_d;
  logic [ADDR_W-1:0] opsum_q, opsum_d;
  logic [ADDR_W-1:0] ifmap_base_q, ifmap_base_d;
  logic [ADDR_W-1:0] filter_stride_q, filter_stride_d;
  logic [ADDR_W-1:0] ifmap_stride_q, ifmap_stride_d;
  logic [ADDR_W-1:0] bias_stride_q, bias_stride_d;
  logic [ADDR_W-1:0] opsum_stride_q, opsum_stride_d;

  always_comb begin
    filter_d        = filter_q;
    ifmap_d         = ifmap_q;
    bias_d          = bias_q;
    opsum_d         = opsum_q;
    ifmap_base_d    = ifmap_base_q;
    filter_stride_d = filter_stride_q;
    ifmap_stride_d  = ifmap_stride_q;
    bias_stride_d   = bias_stride_q;
    opsum_stride_d  = opsum_stride_q;
    if (load_i) begin
      filter_d        = filter_base_i;
      ifmap_d         = ifmap_base_i;
      bias_d          = bias_base_i;
      opsum_d         = opsum_base_i;
      ifmap_base_d    = ifmap_base_i;
      filter_stride_d = filter_stride_i;
      ifmap_stride_d  = ifmap_stride_i;
      bias_stride_d   = bias_stride_i;
      opsum_stride_d  = opsum_stride_i;
    end else if (step_m_i) begin
      filter_d = filter_q + filter_stride_q;
      ifmap_d  = ifmap_base_q;
      bias_d   = bias_q + bias_stride_q;
      opsum_d  = opsum_q + opsum_stride_q;
    end else if (step_c_i) begin
      filter_d = filter_q + filter_stride_q;
      ifmap_d  = ifmap_q + ifmap_stride_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      filter_q        <= '0;
      ifmap_q         <= '0;
      bias_q          <= '0;
      opsum_q         <= '0;
      ifmap_base_q    <= '0;
      filter_stride_q <= '0;
      ifmap_stride_q  <= '0;
      bias_stride_q   <= '0;
      opsum_stride_q  <= '0;
    end else begin
      filter_q        <= filter_d;
      ifmap_q         <= ifmap_d;
      bias_q          <= bias_d;
      opsum_q         <= opsum_d;
      ifmap_base_q    <= ifmap_base_d;
      filter_stride_q <= filter_stride_d;
      ifmap_stride_q  <= ifmap_stride_d;
      bias_stride_q   <= bias_stride_d;
      opsum_stride_q  <= opsum_stride_d;
    end
  end

  assign filter_addr_o = filter_q;
  assign ifmap_addr_o  = ifmap_q;
  assign bias_addr_o   = bias_q;
  assign opsum_addr_o  = opsum_q;

endmodule

// File: rtl/pass_scheduler.sv
// Layer-level sequencer in front of the pass controller. Splits a layer into an
// m_tiles x c_tiles loop of passes (c innermost), drives the controller's config and base
// addresses, pulses op_config[0] for one cycle per pass and waits for pass_done_i.
// Pass c==0 of each output tile reads bias; later passes accumulate onto the stored opsum.
//   clk_i / rst_ni            : clock, synchronous active-low reset
//   start_i                   : launch-layer pulse (honoured in IDLE only)
//   layer_*_i, *_tiles_i      : layer configuration, latched on start
//   *_base_i / *_stride_i     : region base addresses and per-tile strides
//   op_config_o .. shape_*_o  : controller configuration (op_config[0] = pass start)
//   *_baseaddr_o              : controller base addresses for the current pass
//   bias_ipsum_sel_o          : 1 = read bias, 0 = read ipsum
//   pass_done_i               : controller done pulse (honoured in WAIT only)
//   busy_o, layer_done_o      : status; layer_done_o is a one-cycle pulse
//   m_idx_o, c_idx_o          : current tile indices
//   error_o                   : sticky pass timeout flag
// Optional macro PASS_SCHED_TIMEOUT_EN enables a per-pass watchdog of TIMEOUT_CYCLES WAIT
// cycles; without it error_o is tied low and WAIT waits indefinitely.
module pass_scheduler
  import pass_sched_pkg::*;
#(
  parameter int unsigned TILE_BITS      = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [31:0]          layer_op_config_i,
  input  logic [31:0]          layer_mapping_param_i,
  input  logic [31:0]          layer_shape_param1_i,
  input  logic [31:0]          layer_shape_param2_i,
  input  logic [TILE_BITS-1:0] m_tiles_i,
  input  logic [TILE_BITS-1:0] c_tiles_i,
  input  logic [ADDR_W-1:0]    filter_base_i,
  input  logic [ADDR_W-1:0]    ifmap_base_i,
  input  logic [ADDR_W-1:0]    bias_base_i,
  input  logic [ADDR_W-1:0]    opsum_base_i,
  input  logic [ADDR_W-1:0]    filter_stride_i,
  input  logic [ADDR_W-1:0]    ifmap_stride_i,
  input  logic [ADDR_W-1:0]    bias_stride_i,
  input  logic [ADDR_W-1:0]    opsum_stride_i,
  output logic [31:0]          op_config_o,
  output logic [31:0]          mapping_param_o,
  output logic [31:0]          shape_param1_o,
  output logic [31:0]          shape_param2_o,
  output logic [ADDR_W-1:0]    filter_baseaddr_o,
  output logic [ADDR_W-1:0]    ifmap_baseaddr_o,
  output logic [ADDR_W-1:0]    bias_baseaddr_o,
  output logic [ADDR_W-1:0]    opsum_baseaddr_o,
  output logic                 bias_ipsum_sel_o,
  input  logic                 pass_done_i,
  output logic                 busy_o,
  output logic                 layer_done_o,
  output logic [TILE_BITS-1:0] m_idx_o,
  output logic [TILE_BITS-1:0] c_idx_o,
  output logic                 error_o
);

  localparam logic [TILE_BITS-1:0] TileOne = TILE_BITS'(1);

  pass_state_t state_q, state_d;

  logic [31:0]          op_config_q, op_config_d;
  logic [31:0]          mapping_q, mapping_d;
  logic [31:0]          shape1_q, shape1_d;
  logic [31:0]          shape2_q, shape2_d;
  logic [TILE_BITS-1:0] m_tiles_q, m_tiles_d;
  logic [TILE_BITS-1:0] c_tiles_q, c_tiles_d;
  logic [TILE_BITS-1:0] m_idx_q, m_idx_d;
  logic [TILE_BITS-1:0] c_idx_q, c_idx_d;
  logic                 sel_q, sel_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic load, step_c, step_m;
  logic last_c, last_m;

  assign last_c = (c_idx_q == c_tiles_q - TileOne);
  assign last_m = (m_idx_q == m_tiles_q - TileOne);

`ifdef PASS_SCHED_TIMEOUT_EN
  localparam logic [31:0] WdogLast = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] wdog_q, wdog_d;
  logic        error_q, error_d;
  logic        unused_bits;
  assign unused_bits = layer_op_config_i[OP_START_BIT];
`else
  logic unused_bits;
  assign unused_bits = ^{layer_op_config_i[OP_START_BIT], TIMEOUT_CYCLES};
`endif

  always_comb begin
    state_d     = state_q;
    op_config_d = op_config_q;
    mapping_d   = mapping_q;
    shape1_d    = shape1_q;
    shape2_d    = shape2_q;
    m_tiles_d   = m_tiles_q;
    c_tiles_d   = c_tiles_q;
    m_idx_d     = m_idx_q;
    c_idx_d     = c_idx_q;
    sel_d       = sel_q;
    load        = 1'b0;
    step_c      = 1'b0;
    step_m      = 1'b0;
`ifdef PASS_SCHED_TIMEOUT_EN
    error_d     = error_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          op_config_d = {layer_op_config_i[31:1], 1'b0};
          mapping_d   = layer_mapping_param_i;
          shape1_d    = layer_shape_param1_i;
          shape2_d    = layer_shape_param2_i;
          m_tiles_d   = m_tiles_i;
          c_tiles_d   = c_tiles_i;
          m_idx_d     = '0;
          c_idx_d     = '0;
          sel_d       = 1'b1;
          load        = 1'b1;
`ifdef PASS_SCHED_TIMEOUT_EN
          error_d     = 1'b0;
`endif
          if (m_tiles_i == '0 || c_tiles_i == '0) begin
            state_d = StDone;
          end else begin
            state_d                  = StLaunch;
            op_config_d[OP_START_BIT] = 1'b1;
          end
        end
      end
      StLaunch: begin
        state_d                  = StWait;
        op_config_d[OP_START_BIT] = 1'b0;
      end
      StWait: begin
        if (pass_done_i) begin
          state_d = StNext;
`ifdef PASS_SCHED_TIMEOUT_EN
        end else if (wdog_q == WdogLast) begin
          error_d = 1'b1;
          state_d = StDone;
`endif
        end
      end
      StNext: begin
        if (last_c && last_m) begin
          state_d = StDone;
        end else begin
          if (last_c) begin
            c_idx_d = '0;
            m_idx_d = m_idx_q + TileOne;
            step_m  = 1'b1;
          end else begin
            c_idx_d = c_idx_q + TileOne;
            step_c  = 1'b1;
          end
          sel_d                    = (c_idx_d == '0);
          state_d                  = StLaunch;
          op_config_d[OP_START_BIT] = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Status flags are registered copies of the upcoming state.
    busy_d = (state_d != StIdle);
    done_d = (state_d == StDone);
  end

`ifdef PASS_SCHED_TIMEOUT_EN
  always_comb begin
    wdog_d = wdog_q;
    if (state_d == StLaunch) begin
      wdog_d = '0;
    end else if (state_q == StWait) begin
      wdog_d = wdog_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wdog_q  <= '0;
      error_q <= 1'b0;
    end else begin
      wdog_q  <= wdog_d;
      error_q <= error_d;
    end
  end

  assign error_o = error_q;
`else
  assign error_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      op_config_q <= '0;
      mapping_q   <= '0;
      shape1_q    <= '0;
      shape2_q    <= '0;
      m_tiles_q   <= '0;
      c_tiles_q   <= '0;
      m_idx_q     <= '0;
      c_idx_q     <= '0;
      sel_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_config_q <= op_config_d;
      mapping_q   <= mapping_d;
      shape1_q    <= shape1_d;
      shape2_q    <= shape2_d;
      m_tiles_q   <= m_tiles_d;
      c_tiles_q   <= c_tiles_d;
      m_idx_q     <= m_idx_d;
      c_idx_q     <= c_idx_d;
      sel_q       <= sel_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  pass_addr_gen u_addr_gen (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .load_i          (load),
    .step_c_i        (step_c),
    .step_m_i        (step_m),
    .filter_base_i   (filter_base_i),
    .ifmap_base_i    (ifmap_base_i),
    .bias_base_i     (bias_base_i),
    .opsum_base_i    (opsum_base_i),
    .filter_stride_i (filter_stride_i),
    .ifmap_stride_i  (ifmap_stride_i),
    .bias_stride_i   (bias_stride_i),
    .opsum_stride_i  (opsum_stride_i),
    .filter_addr_o   (filter_baseaddr_o),
    .ifmap_addr_o    (ifmap_baseaddr_o),
    .bias_addr_o     (bias_baseaddr_o),
    .opsum_addr_o    (opsum_baseaddr_o)
  );

  assign op_config_o      = op_config_q;
  assign mapping_param_o  = mapping_q;
  assign shape_param1_o   = shape1_q;
  assign shape_param2_o   = shape2_q;
  assign bias_ipsum_sel_o = sel_q;
  assign busy_o           = busy_q;
  assign layer_done_o     = done_q;
  assign m_idx_o          = m_idx_q;
  assign c_idx_o          = c_idx_q;

endmodule

// File: tb/tb_pass_scheduler.sv
// Self-checking bench for pass_scheduler. The bench plays the pass controller and compares
// every launch against addresses computed directly from pass numbers (base + k*stride).
module tb_pass_scheduler;

  localparam int unsigned TB_TILE = 8;
  localparam int unsigned TB_TO   = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_ni = 1'b0;
  logic               start_i = 1'b0;
  logic               pass_done_i = 1'b0;
  logic [31:0]        d_op, d_map, d_sh1, d_sh2;
  logic [TB_TILE-1:0] d_mt, d_ct;
  logic [31:0]        d_fb, d_ib, d_bb, d_ob, d_fs, d_is, d_bs, d_os;

  logic [31:0]        op_config_o, mapping_param_o, shape_param1_o, shape_param2_o;
  logic [31:0]        filter_baseaddr_o, ifmap_baseaddr_o, bias_baseaddr_o, opsum_baseaddr_o;
  logic               bias_ipsum_sel_o, busy_o, layer_done_o, error_o;
  logic [TB_TILE-1:0] m_idx_o, c_idx_o;

  // Model copy of the layer under test.
  logic [31:0] e_op, e_map, e_sh1, e_sh2;
  logic [31:0] e_fb, e_ib, e_bb, e_ob, e_fs, e_is, e_bs, e_os;

  int errors = 0;
  int checks = 0;

  pass_scheduler #(
    .TILE_BITS      (TB_TILE),
    .TIMEOUT_CYCLES (TB_TO)
  ) dut (
    .clk_i                 (clk),
    .rst_ni                (rst_ni),
    .start_i               (start_i),
    .layer_op_config_i     (d_op),
    .layer_mapping_param_i (d_map),
    .layer_shape_param1_i  (d_sh1),
    .layer_shape_param2_i  (d_sh2),
    .m_tiles_i             (d_mt),
    .c_tiles_i             (d_ct),
    .filter_base_i         (d_fb),
    .ifmap_base_i          (d_ib),
    .bias_base_i           (d_bb),
    .opsum_base_i          (d_ob),
    .filter_stride_i       (d_fs),
    .ifmap_stride_i        (d_is),
    .bias_stride_i         (d_bs),
    .opsum_stride_i        (d_os),
    .op_config_o           (op_config_o),
    .mapping_param_o       (mapping_param_o),
    .shape_param1_o        (shape_param1_o),
    .shape_param2_o        (shape_param2_o),
    .filter_baseaddr_o     (filter_baseaddr_o),
    .ifmap_baseaddr_o      (ifmap_baseaddr_o),
    .bias_baseaddr_o       (bias_baseaddr_o),
    .opsum_baseaddr_o      (opsum_baseaddr_o),
    .bias_ipsum_sel_o      (bias_ipsum_sel_o),
    .pass_done_i           (pass_done_i),
    .busy_o                (busy_o),
    .layer_done_o          (layer_done_o),
    .m_idx_o               (m_idx_o),
    .c_idx_o               (c_idx_o),
    .error_o               (error_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_cfg();
    e_op  = $urandom; e_map = $urandom; e_sh1 = $urandom; e_sh2 = $urandom;
    e_fb  = $urandom; e_ib  = $urandom; e_bb  = $urandom; e_ob  = $urandom;
    e_fs  = $urandom; e_is  = $urandom; e_bs  = $urandom; e_os  = $urandom;
  endtask

  task automatic drive_cfg(input int mt, input int ct);
    d_op = e_op; d_map = e_map; d_sh1 = e_sh1; d_sh2 = e_sh2;
    d_fb = e_fb; d_ib = e_ib; d_bb = e_bb; d_ob = e_ob;
    d_fs = e_fs; d_is = e_is; d_bs = e_bs; d_os = e_os;
    d_mt = TB_TILE'(mt); d_ct = TB_TILE'(ct);
  endtask

  // Garbage on the inputs after start shows the layer was latched.
  task automatic scramble_inputs();
    d_op = $urandom; d_map = $urandom; d_sh1 = $urandom; d_sh2 = $urandom;
    d_fb = $urandom; d_ib = $urandom; d_bb = $urandom; d_ob = $urandom;
    d_fs = $urandom; d_is = $urandom; d_bs = $urandom; d_os = $urandom;
    d_mt = TB_TILE'($urandom); d_ct = TB_TILE'($urandom);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_opcfg"}, op_config_o, 32'h0);
    check({tag, "_map"}, mapping_param_o | shape_param1_o | shape_param2_o, 32'h0);
    check({tag, "_addr"},
          filter_baseaddr_o | ifmap_baseaddr_o | bias_baseaddr_o | opsum_baseaddr_o, 32'h0);
    check({tag, "_flags"},
          {27'h0, bias_ipsum_sel_o, busy_o, layer_done_o, error_o, 1'b0}, 32'h0);
    check({tag, "_idx"}, {16'h0, m_idx_o, c_idx_o}, 32'h0);
  endtask

  // Runs one layer acting as the controller. abort_k >= 0 resets during WAIT of that pass.
  // poke pulses start during WAIT; restart asserts start during DONE and leaves it high.
  task automatic run_layer(input int mt, input int ct, input int abort_k, input bit poke,
                           input bit restart);
    int k;
    int d;
    logic [31:0] ef, ei, eb, eo;
    drive_cfg(mt, ct);
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    scramble_inputs();
    if (mt == 0 || ct == 0) begin
      check("degen_done", {31'h0, layer_done_o}, 32'h1);
      check("degen_no_launch", {31'h0, op_config_o[0]}, 32'h0);
      step();
      check("degen_idle", {30'h0, busy_o, layer_done_o}, 32'h0);
      return;
    end
    k = 0;
    for (int m = 0; m < mt; m++) begin
      for (int c = 0; c < ct; c++) begin
        ef = e_fb + 32'(k) * e_fs;
        ei = e_ib + 32'(c) * e_is;
        eb = e_bb + 32'(m) * e_bs;
        eo = e_ob + 32'(m) * e_os;
        check("launch_bit", {31'h0, op_config_o[0]}, 32'h1);
        check("op_cfg_hi", {op_config_o[31:1], 1'b0}, {e_op[31:1], 1'b0});
        check("mapping", mapping_param_o, e_map);
        check("shapes", shape_param1_o ^ shape_param2_o, e_sh1 ^ e_sh2);
        check("filter_addr", filter_baseaddr_o, ef);
        check("ifmap_addr", ifmap_baseaddr_o, ei);
        check("bias_addr", bias_baseaddr_o, eb);
        check("opsum_addr", opsum_baseaddr_o, eo);
        check("bias_sel", {31'h0, bias_ipsum_sel_o}, {31'h0, c == 0});
        check("idx", {16'h0, m_idx_o, c_idx_o}, {16'h0, 8'(m), 8'(c)});
        check("launch_status", {29'h0, busy_o, layer_done_o, error_o}, 32'h4);
        step();
        check("wait_bit_low", {31'h0, op_config_o[0]}, 32'h0);
        if (k == abort_k) begin
          rst_ni = 1'b0;
          step();
          rst_ni = 1'b1;
          check_all_zero("reset_mid");
          return;
        end
        d = poke ? int'($urandom_range(1, 4)) : int'($urandom_range(0, 4));
        for (int i = 0; i < d; i++) begin
          if (poke && i == 0) start_i = 1'b1;
          step();
          start_i = 1'b0;
          check("wait_hold_bit", {31'h0, op_config_o[0]}, 32'h0);
          check("wait_hold_filter", filter_baseaddr_o, ef);
          check("wait_hold_idx", {16'h0, m_idx_o, c_idx_o}, {16'h0, 8'(m), 8'(c)});
        end
        pass_done_i = 1'b1;
        step();
        pass_done_i = 1'b0;
        check("next_state", {30'h0, busy_o, op_config_o[0]}, 32'h2);
        check("next_no_done", {31'h0, layer_done_o}, 32'h0);
        check("next_ifmap_hold", ifmap_baseaddr_o, ei);
        step();
        k++;
      end
    end
    check("layer_done", {31'h0, layer_done_o}, 32'h1);
    check("done_no_launch", {30'h0, op_config_o[0], error_o}, 32'h0);
    check("done_passes", 32'(k), 32'(mt * ct));
    if (restart) start_i = 1'b1;
    step();
    check("idle_after_done", {29'h0, busy_o, layer_done_o, op_config_o[0]}, 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rand_cfg();
    drive_cfg(1, 1);
    // Reset state
    step();
    step();
    check_all_zero("reset");
    rst_ni = 1'b1;
    step();
    check_all_zero("after_reset");

    // Single pass with fixed bases
    rand_cfg();
    e_fb = 32'h1000; e_ib = 32'h2000; e_bb = 32'h3000; e_ob = 32'h4000;
    run_layer(1, 1, -1, 1'b0, 1'b0);

    // 2x3 with 0x100 strides and filter base 0
    rand_cfg();
    e_fb = 32'h0;
    e_fs = 32'h100; e_is = 32'h100; e_bs = 32'h100; e_os = 32'h100;
    run_layer(2, 3, -1, 1'b0, 1'b0);

    // pass_done while idle is ignored
    pass_done_i = 1'b1;
    step();
    pass_done_i = 1'b0;
    check("idle_pass_done", {30'h0, busy_o, op_config_o[0]}, 32'h0);
    step();
    check("idle_pass_done2", {30'h0, busy_o, op_config_o[0]}, 32'h0);

    // Degenerate layers
    rand_cfg();
    run_layer(0, 3, -1, 1'b0, 1'b0);
    run_layer(2, 0, -1, 1'b0, 1'b0);

    // start during WAIT is ignored
    rand_cfg();
    run_layer(2, 2, -1, 1'b1, 1'b0);

    // Reset during WAIT of pass 3, then a full layer
    rand_cfg();
    run_layer(2, 3, 3, 1'b0, 1'b0);
    rand_cfg();
    run_layer(2, 3, -1, 1'b0, 1'b0);

    // start held through DONE: ignored there, accepted in the following IDLE cycle
    rand_cfg();
    run_layer(1, 2, -1, 1'b0, 1'b1);
    rand_cfg();
    run_layer(2, 1, -1, 1'b0, 1'b0);

    // Random layers
    for (int r = 0; r < 6; r++) begin
      rand_cfg();
      run_layer(int'($urandom_range(1, 3)), int'($urandom_range(1, 4)), -1,
                1'($urandom_range(0, 1)), 1'b0);
    end

`ifdef PASS_SCHED_TIMEOUT_EN
    // Withheld pass_done: WAIT lasts TB_TO cycles, then DONE with error set
    rand_cfg();
    drive_cfg(1, 1);
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    check("to_launch", {31'h0, op_config_o[0]}, 32'h1);
    n = 0;
    while (layer_done_o !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    check("to_latency", 32'(n), 32'(TB_TO + 1));
    check("to_error", {31'h0, error_o}, 32'h1);
    step();
    check("to_idle", {30'h0, busy_o, error_o}, 32'h1);
    rand_cfg();
    run_layer(1, 2, -1, 1'b0, 1'b0);
`else
    check("no_error", {31'h0, error_o}, 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
